// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter on the RAT output-port bus.
//
// A rising edge of (IO_STRB & PORT_ID==DATA_ID) pushes OUT_PORT into a small
// FIFO. An FSM pops bytes and shifts them out LSB first on TX. STATUS reports
// {5'b0, OVERRUN, BUSY, FULL}. The top-level input mux places STATUS on IN_PORT
// when STAT_ID is read.
//
// Ports:
//   CLK       in   board clock
//   RESET     in   asynchronous, active-high reset
//   PORT_ID   in   MCU port ID
//   OUT_PORT  in   MCU output data
//   IO_STRB   in   MCU output strobe (may stay high for several cycles)
//   TX        out  serial line, idles high, registered
//   STATUS    out  {5'b0, OVERRUN, BUSY, FULL}
module uart_tx_port #(
    parameter logic [7:0]  DATA_ID      = 8'h42,
    parameter logic [7:0]  STAT_ID      = 8'h43,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic       TX,
    output logic [7:0] STATUS
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    // Elaboration-time sanity checks on the configuration.
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_port: CLKS_PER_BIT must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_port: FIFO_DEPTH must be a power of two >= 2");
    end
    if (STAT_ID == DATA_ID) begin : g_bad_ids
        $error("uart_tx_port: STAT_ID and DATA_ID must differ");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overrun_q, overrun_d;
    logic          wr_req, wr_req_q, push, pop, bit_done;

    logic [7:0]    mem [0:FIFO_DEPTH-1];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic          empty, full, push_ok;

    // Write detect: one push per strobe, on its rising edge only.
    assign wr_req = IO_STRB && (PORT_ID == DATA_ID);
    assign push   = wr_req && !wr_req_q;

    // Extra pointer MSB distinguishes full from empty.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (count == (AW + 1)'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a push at FULL is still accepted.
    assign push_ok = push && (!full || pop);

    assign wr_ptr_d  = push_ok ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    assign rd_ptr_d  = pop ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    assign overrun_d = overrun_q || (push && !push_ok);

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= OUT_PORT;
        end
    end

    assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // Next-state logic; the baud counter is cleared on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q[AW-1:0]];
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level for the current state; registered so TX never glitches.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            overrun_q <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            overrun_q <= overrun_d;
            wr_req_q  <= wr_req;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    assign TX     = tx_q;
    assign STATUS = {5'b00000, overrun_q, (state_q != StIdle) || !empty, full};

endmodule
